// File: rtl/program_counter_ras_pkg.sv
// rtl/program_counter_ras_pkg.sv - shared types for the fetch PC with return-address stack
package program_counter_ras_pkg;

   typedef enum logic [2:0] {
      PC_SEQ,
      PC_BR,
      PC_J,
      PC_JR,
      PC_RAS,
      PC_REDIR
   } pc_sel_t;

   localparam int RAS_DEPTH_DEFAULT = 8;

endpackage

// File: rtl/program_counter_ras_if.sv
// rtl/program_counter_ras_if.sv - fetch control / PC bundle between pipeline and PC block
interface program_counter_ras_if #(
   parameter int PC_W   = 32,
   parameter int JIMM_W = 26
);
   logic              ihit;
   logic              stall;
   logic              redirect;
   logic [PC_W-1:0]   redirect_addr;
   logic              Branch;
   logic              Jump;
   logic              JR;
   logic              Call;
   logic              Ret;
   logic [PC_W-1:0]   bimm;
   logic [JIMM_W-1:0] jimm;
   logic [PC_W-1:0]   jraddr;
   logic [PC_W-1:0]   pcaddr;
   logic [PC_W-1:0]   npc;
   logic              ras_empty;
   logic              ras_full;
   logic              ras_ovf;
   logic              ras_unf;

   modport pc (
      input  ihit, stall, redirect, redirect_addr, Branch, Jump, JR, Call, Ret,
             bimm, jimm, jraddr,
      output pcaddr, npc, ras_empty, ras_full, ras_ovf, ras_unf
   );

   modport tb (
      output ihit, stall, redirect, redirect_addr, Branch, Jump, JR, Call, Ret,
             bimm, jimm, jraddr,
      input  pcaddr, npc, ras_empty, ras_full, ras_ovf, ras_unf
   );
endinterface

// File: rtl/program_counter_ras_ras_stack.sv
// rtl/program_counter_ras_ras_stack.sv - circular return-address stack with push/pop/replace and flags
module ras_stack #(
   parameter int DEPTH = 8,
   parameter int W     = 32
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_push,
   input  logic         i_pop,
   input  logic [W-1:0] i_data,
   output logic [W-1:0] o_top,
   output logic         o_empty,
   output logic         o_full,
   output logic         o_ovf,
   output logic         o_unf
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_top;
   logic [CW-1:0] r_count;
   logic          r_empty;
   logic          r_full;
   logic          r_ovf;
   logic          r_unf;

   logic [PW-1:0] w_top_n;
   logic [CW-1:0] w_count_n;
   logic          w_wr;
   logic [PW-1:0] w_wr_idx;
   logic          w_ovf_set;
   logic          w_unf_set;
   logic          w_is_full;
   logic          w_is_empty;

   assign w_is_full  = (r_count == FULL_CNT);
   assign w_is_empty = (r_count == '0);

   always_comb begin
      w_top_n   = r_top;
      w_count_n = r_count;
      w_wr      = 1'b0;
      w_wr_idx  = r_top;
      w_ovf_set = 1'b0;
      w_unf_set = 1'b0;
      // A replace (push+pop) on an empty stack degenerates to a plain push.
      if (i_push && (!i_pop || w_is_empty)) begin
         w_wr     = 1'b1;
         w_wr_idx = r_top + PW'(1);
         w_top_n  = r_top + PW'(1);
         if (w_is_full) begin
            w_ovf_set = 1'b1;
         end else begin
            w_count_n = r_count + CW'(1);
         end
      end else if (i_push && i_pop) begin
         w_wr     = 1'b1;
         w_wr_idx = r_top;
      end else if (i_pop) begin
         if (w_is_empty) begin
            w_unf_set = 1'b1;
         end else begin
            w_top_n   = r_top - PW'(1);
            w_count_n = r_count - CW'(1);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_top   <= '0;
         r_count <= '0;
         r_empty <= 1'b1;
         r_full  <= 1'b0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else begin
         r_top   <= w_top_n;
         r_count <= w_count_n;
         r_empty <= (w_count_n == '0);
         r_full  <= (w_count_n == FULL_CNT);
         r_ovf   <= r_ovf | w_ovf_set;
         r_unf   <= w_unf_set;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst && w_wr) begin
         r_mem[w_wr_idx] <= i_data;
      end
   end

   assign o_top   = r_mem[r_top];
   assign o_empty = r_empty;
   assign o_full  = r_full;
   assign o_ovf   = r_ovf;
   assign o_unf   = r_unf;

endmodule

// File: rtl/program_counter_ras.sv
// rtl/program_counter_ras.sv - fetch PC register and next-PC mux with RAS-predicted returns
module program_counter_ras
   import program_counter_ras_pkg::*;
#(
   parameter int              PC_W      = 32,
   parameter int              JIMM_W    = 26,
   parameter logic [PC_W-1:0] RESET_PC  = '0,
   parameter int              RAS_DEPTH = RAS_DEPTH_DEFAULT,
   parameter bit              USE_RAS   = 1'b1
) (
   input logic               CLK,
   input logic               RST,
   program_counter_ras_if.pc bus
);
   logic [PC_W-1:0] r_pc;
   logic [PC_W-1:0] w_npc;
   logic [PC_W-1:0] w_br_tgt;
   logic [PC_W-1:0] w_j_tgt;
   logic [PC_W-1:0] w_ras_top;
   logic [PC_W-1:0] w_next;
   logic [PC_W-1:0] w_next_al;
   logic            w_adv;
   logic            w_load;
   logic            w_ras_upd;
   logic            w_ras_empty;
   pc_sel_t         w_sel;

   assign w_adv     = bus.ihit & ~bus.stall;
   assign w_load    = bus.redirect | w_adv;
   assign w_ras_upd = w_adv & ~bus.redirect;

   assign w_npc    = r_pc + PC_W'(4);
   assign w_br_tgt = w_npc + {bus.bimm[PC_W-3:0], 2'b00};
   assign w_j_tgt  = {w_npc[PC_W-1:JIMM_W+2], bus.jimm, 2'b00};

   always_comb begin
      w_sel = PC_SEQ;
      if (bus.redirect) begin
         w_sel = PC_REDIR;
      end else if (bus.JR) begin
         w_sel = (bus.Ret && USE_RAS && !w_ras_empty) ? PC_RAS : PC_JR;
      end else if (bus.Branch) begin
         w_sel = PC_BR;
      end else if (bus.Jump) begin
         w_sel = PC_J;
      end
   end

   always_comb begin
      w_next = w_npc;
      case (w_sel)
         PC_REDIR: w_next = bus.redirect_addr;
         PC_RAS:   w_next = w_ras_top;
         PC_JR:    w_next = bus.jraddr;
         PC_BR:    w_next = w_br_tgt;
         PC_J:     w_next = w_j_tgt;
         default:  w_next = w_npc;
      endcase
      w_next_al = w_next & ~PC_W'(3);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_pc <= RESET_PC;
      end else if (w_load) begin
         r_pc <= w_next_al;
      end
   end

   ras_stack #(
      .DEPTH (RAS_DEPTH),
      .W     (PC_W)
   ) u_ras (
      .i_clk   (CLK),
      .i_rst   (RST),
      .i_push  (bus.Call & w_ras_upd),
      .i_pop   (bus.Ret & w_ras_upd),
      .i_data  (w_npc),
      .o_top   (w_ras_top),
      .o_empty (w_ras_empty),
      .o_full  (bus.ras_full),
      .o_ovf   (bus.ras_ovf),
      .o_unf   (bus.ras_unf)
   );

   assign bus.ras_empty = w_ras_empty;
   assign bus.pcaddr    = r_pc;
   assign bus.npc       = w_npc;

endmodule
